// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: interrupt front end for a 6502-style sequencer.
//   Synchronises N_IRQ maskable lines plus NMI and SO, tracks per-channel
//   level/edge pending state, resolves fixed priority (channel 0 highest,
//   NMI over IRQ) and latches the decision on T0 & NEXT_T until acknowledged.
// Ports:
//   clk, RESET          clock, asynchronous active-high reset
//   nIRQ, nNMI, nSO     asynchronous active-low request lines
//   T0, NEXT_T, I_mask  sequencer state: instruction boundary, cycle advance, I flag
//   irq_en, ack         per-channel enable, vector-fetched pulse
//   nNMI_req, nIRQ_req  live request status (active low)
//   nNMI_T0, nIRQ_T0    decision latched at the last T0 & NEXT_T (active low)
//   irq_idx             channel chosen at the last decision
//   irq_pending         raw pending vector, before enable and mask
//   SO_req              one-cycle set-overflow pulse
// Latency: line change before edge 1 reaches the pending/latch registers at edge SYNC_STAGES+1.
module irq_priority_ctrl #(
  parameter int                 N_IRQ       = 4,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0]   EDGE_MODE   = '0,
  localparam int                IDX_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [N_IRQ-1:0] nIRQ,
  input  logic             nNMI,
  input  logic             nSO,
  input  logic             T0,
  input  logic             NEXT_T,
  input  logic             I_mask,
  input  logic [N_IRQ-1:0] irq_en,
  input  logic             ack,
  output logic             nNMI_req,
  output logic             nIRQ_req,
  output logic             nNMI_T0,
  output logic             nIRQ_T0,
  output logic [IDX_W-1:0] irq_idx,
  output logic [N_IRQ-1:0] irq_pending,
  output logic             SO_req
);

  // Line vector layout: [N_IRQ-1:0] = nIRQ, [N_IRQ] = nNMI, [N_IRQ+1] = nSO.
  localparam int LW = N_IRQ + 2;

  logic [SYNC_STAGES-1:0][LW-1:0] sync_q;
  logic [LW-1:0]                  line_s;
  logic [LW-1:0]                  prev_q;
  logic [LW-1:0]                  fall;
  logic [SYNC_STAGES:0]           arm_q;

  logic [N_IRQ-1:0] pend_q, pend_d, en_pend;
  logic             nmi_q, nmi_d;
  logic             so_pend_q, so_pend_d, so_req_q, so_req_d, so_evt;
  logic             nnmi_t0_q, nnmi_t0_d, nirq_t0_q, nirq_t0_d;
  logic [IDX_W-1:0] idx_q, idx_d, low_idx;
  logic             any_en, decide, nmi_clr, irq_clr;

  // Synchroniser chain, previous-value register for edge detection, and an
  // arming shift register. Edges are suppressed until the chain holds real
  // line samples, so a line held low through reset does not look like a
  // falling edge once the reset-value ones drain out.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sync_q <= '1;
      prev_q <= '1;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {nSO, nNMI, nIRQ}};
      prev_q <= line_s;
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign line_s = sync_q[SYNC_STAGES-1];
  assign fall   = arm_q[SYNC_STAGES] ? (prev_q & ~line_s) : '0;

  assign en_pend  = pend_q & irq_en;
  assign decide   = T0 & NEXT_T;
  assign nmi_clr  = ack & ~nnmi_t0_q;
  assign irq_clr  = ack & nnmi_t0_q & ~nirq_t0_q;

  assign nNMI_req    = ~nmi_q;
  assign nIRQ_req    = ~(any_en & ~I_mask);
  assign nNMI_T0     = nnmi_t0_q;
  assign nIRQ_T0     = nirq_t0_q;
  assign irq_idx     = idx_q;
  assign irq_pending = pend_q;
  assign SO_req      = so_req_q;

  // Lowest-index enabled pending channel; scanning downward lets the lowest win.
  always_comb begin
    any_en  = 1'b0;
    low_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (en_pend[i]) begin
        any_en  = 1'b1;
        low_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (EDGE_MODE[i]) begin
        // A new edge in the same clk as the clearing ack keeps the channel set.
        pend_d[i] = fall[i] | (pend_q[i] & ~(irq_clr & (idx_q == IDX_W'(i))));
      end else begin
        pend_d[i] = ~line_s[i];
      end
    end

    nmi_d = fall[N_IRQ] | (nmi_q & ~nmi_clr);

    // SO pulses on the first advancing cycle, including the edge cycle itself.
    so_evt    = fall[N_IRQ+1] | so_pend_q;
    so_req_d  = so_evt & NEXT_T;
    so_pend_d = so_evt & ~NEXT_T;

    nnmi_t0_d = nnmi_t0_q;
    nirq_t0_d = nirq_t0_q;
    idx_d     = idx_q;
    if (decide) begin
      nnmi_t0_d = nNMI_req;
      nirq_t0_d = nIRQ_req | ~nNMI_req;
      if (any_en) begin
        idx_d = low_idx;
      end
    end else if (nmi_clr) begin
      nnmi_t0_d = 1'b1;
    end else if (irq_clr) begin
      nirq_t0_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      pend_q    <= '0;
      nmi_q     <= 1'b0;
      so_pend_q <= 1'b0;
      so_req_q  <= 1'b0;
      nnmi_t0_q <= 1'b1;
      nirq_t0_q <= 1'b1;
      idx_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      nmi_q     <= nmi_d;
      so_pend_q <= so_pend_d;
      so_req_q  <= so_req_d;
      nnmi_t0_q <= nnmi_t0_d;
      nirq_t0_q <= nirq_t0_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl: directed scenarios followed by random traffic,
// every cycle's outputs predicted by a reference model working from the input
// history, queued, and compared by an independent monitor on the falling edge.
module tb_irq_priority_ctrl;

  localparam int            N  = 4;
  localparam int            SS = 2;
  localparam int            LW = N + 2;
  localparam logic [N-1:0]  EM = 4'b1001;   // channels 0 and 3 edge, 1 and 2 level

  logic         clk = 1'b0;
  logic         RESET;
  logic [N-1:0] nIRQ;
  logic         nNMI, nSO, T0, NEXT_T, I_mask, ack;
  logic [N-1:0] irq_en;
  logic         nNMI_req, nIRQ_req, nNMI_T0, nIRQ_T0, SO_req;
  logic [1:0]   irq_idx;
  logic [N-1:0] irq_pending;

  irq_priority_ctrl #(.N_IRQ(N), .SYNC_STAGES(SS), .EDGE_MODE(EM)) dut (
    .clk(clk), .RESET(RESET), .nIRQ(nIRQ), .nNMI(nNMI), .nSO(nSO),
    .T0(T0), .NEXT_T(NEXT_T), .I_mask(I_mask), .irq_en(irq_en), .ack(ack),
    .nNMI_req(nNMI_req), .nIRQ_req(nIRQ_req), .nNMI_T0(nNMI_T0),
    .nIRQ_T0(nIRQ_T0), .irq_idx(irq_idx), .irq_pending(irq_pending),
    .SO_req(SO_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rst;
    logic [N-1:0] nirq;
    logic         nnmi, nso, t0, nt, imask;
    logic [N-1:0] en;
    logic         ack;
  } stim_t;

  typedef struct packed {
    logic         nnmi_req, nirq_req, nnmi_t0, nirq_t0;
    logic [1:0]   idx;
    logic [N-1:0] pend;
    logic         so_req;
  } obs_t;

  obs_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  stim_t         s;

  // Reference model state
  logic [LW-1:0] hist[$];   // hist[k] = {nSO,nNMI,nIRQ} held before edge k+1 after reset release
  int            ecnt;
  logic [N-1:0]  m_pend;
  logic          m_nmi, m_so_pend, m_so_req, m_nnmi_t0, m_nirq_t0;
  int            m_idx;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    ecnt      = 0;
    m_pend    = '0;
    m_nmi     = 1'b0;
    m_so_pend = 1'b0;
    m_so_req  = 1'b0;
    m_nnmi_t0 = 1'b1;
    m_nirq_t0 = 1'b1;
    m_idx     = 0;
  endtask

  // Advance the model by one rising edge using the inputs held before it.
  task automatic model_edge();
    logic [LW-1:0] cur, prv, fall;
    logic          nreq_nmi, nreq_irq, clr_nmi, clr_irq, so_evt;
    int            lo;
    if (RESET) begin
      model_reset();
      return;
    end
    hist.push_back({nSO, nNMI, nIRQ});
    ecnt++;
    // The registers see the line as it was SS edges ago; edges are only
    // trusted once both compared samples are real post-reset samples.
    cur  = (ecnt > SS)     ? hist[ecnt-SS-1] : {LW{1'b1}};
    prv  = (ecnt > SS + 1) ? hist[ecnt-SS-2] : {LW{1'b1}};
    fall = (ecnt >= SS + 2) ? (prv & ~cur) : '0;

    nreq_nmi = !m_nmi;
    nreq_irq = !(((m_pend & irq_en) != 0) && !I_mask);
    lo       = lowest(m_pend & irq_en);
    clr_nmi  = ack && !m_nnmi_t0;
    clr_irq  = ack && m_nnmi_t0 && !m_nirq_t0;

    for (int i = 0; i < N; i++) begin
      if (EM[i]) m_pend[i] = fall[i] || (m_pend[i] && !(clr_irq && m_idx == i));
      else       m_pend[i] = !cur[i];
    end
    m_nmi     = fall[N] || (m_nmi && !clr_nmi);
    so_evt    = fall[N+1] || m_so_pend;
    m_so_req  = so_evt && NEXT_T;
    m_so_pend = so_evt && !NEXT_T;

    if (T0 && NEXT_T) begin
      m_nnmi_t0 = nreq_nmi;
      m_nirq_t0 = nreq_irq || !nreq_nmi;
      if (lo >= 0) m_idx = lo;
    end else if (clr_nmi) begin
      m_nnmi_t0 = 1'b1;
    end else if (clr_irq) begin
      m_nirq_t0 = 1'b1;
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.nnmi_req = !m_nmi;
    o.nirq_req = !(((m_pend & irq_en) != 0) && !I_mask);
    o.nnmi_t0  = m_nnmi_t0;
    o.nirq_t0  = m_nirq_t0;
    o.idx      = 2'(m_idx);
    o.pend     = m_pend;
    o.so_req   = m_so_req;
    return o;
  endfunction

  task automatic apply(input stim_t n);
    RESET  = n.rst;
    nIRQ   = n.nirq;
    nNMI   = n.nnmi;
    nSO    = n.nso;
    T0     = n.t0;
    NEXT_T = n.nt;
    I_mask = n.imask;
    irq_en = n.en;
    ack    = n.ack;
  endtask

  // One cycle: model the edge, drive new inputs just after it, queue the
  // outputs expected for the rest of this cycle.
  task automatic tick(input stim_t n);
    @(posedge clk);
    model_edge();
    #1;
    apply(n);
    if (n.rst) model_reset();
    exp_q.push_back(model_out());
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin : mon
      obs_t want, got;
      want = exp_q.pop_front();
      got  = '{nnmi_req: nNMI_req, nirq_req: nIRQ_req, nnmi_t0: nNMI_T0,
               nirq_t0: nIRQ_T0, idx: irq_idx, pend: irq_pending, so_req: SO_req};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs @%0t got %p want %p", $time, got, want);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    s = '{rst: 1'b1, nirq: '1, nnmi: 1'b1, nso: 1'b1, t0: 1'b0, nt: 1'b1,
          imask: 1'b0, en: '1, ack: 1'b0};
    apply(s);
    model_reset();
    repeat (3) tick(s);
    s.rst = 1'b0;
    repeat (4) tick(s);

    // Level channel 2: request, decision, release, serviced until ack.
    s.nirq[2] = 1'b0; repeat (4) tick(s);
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0;
    s.nirq[2] = 1'b1; repeat (5) tick(s);
    s.ack = 1'b1; tick(s); s.ack = 1'b0; repeat (2) tick(s);

    // Channels 3 (edge) and 1 (level) together, then enable and mask effects.
    s.nirq[3] = 1'b0; s.nirq[1] = 1'b0; tick(s);
    s.nirq[3] = 1'b1; repeat (4) tick(s);
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0; tick(s);
    s.en[1] = 1'b0;
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0; tick(s);
    s.imask = 1'b1; repeat (3) tick(s);
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0; tick(s);
    s.ack = 1'b1; tick(s); s.ack = 1'b0;
    s.imask = 1'b0;
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0; tick(s);
    s.ack = 1'b1; tick(s); s.ack = 1'b0;
    s.nirq[1] = 1'b1; s.en = '1; repeat (4) tick(s);

    // Edge channel 0: sticky, cleared by ack, re-set by an edge in the ack clk.
    s.nirq[0] = 1'b0; tick(s); s.nirq[0] = 1'b1; repeat (4) tick(s);
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0; tick(s);
    s.nirq[0] = 1'b0; tick(s); s.nirq[0] = 1'b1;
    repeat (SS - 1) tick(s);
    s.ack = 1'b1; tick(s); s.ack = 1'b0; repeat (2) tick(s);
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0; tick(s);
    s.ack = 1'b1; tick(s); s.ack = 1'b0; repeat (2) tick(s);

    // NMI wins over a pending IRQ; IRQ taken at the following boundary.
    s.nirq[2] = 1'b0; s.nnmi = 1'b0; tick(s); s.nnmi = 1'b1; repeat (4) tick(s);
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0; tick(s);
    s.ack = 1'b1; tick(s); s.ack = 1'b0; repeat (2) tick(s);
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0; tick(s);
    s.ack = 1'b1; tick(s); s.ack = 1'b0;
    s.nirq[2] = 1'b1; repeat (3) tick(s);

    // NEXT_T low blocks the decision and defers SO.
    s.nnmi = 1'b0; tick(s); s.nnmi = 1'b1; repeat (4) tick(s);
    s.nt = 1'b0; s.t0 = 1'b1; repeat (3) tick(s);
    s.nso = 1'b0; tick(s); s.nso = 1'b1; repeat (5) tick(s);
    s.nt = 1'b1; s.t0 = 1'b0; repeat (3) tick(s);
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0; tick(s);
    s.ack = 1'b1; tick(s); s.ack = 1'b0;
    s.nso = 1'b0; tick(s); s.nso = 1'b1; repeat (4) tick(s);

    // Reset mid-sequence, with edge channel 0 held low through release.
    s.nnmi = 1'b0; s.nirq[0] = 1'b0; tick(s);
    s.nnmi = 1'b1; s.nirq[0] = 1'b1; repeat (4) tick(s);
    s.t0 = 1'b1; tick(s); s.t0 = 1'b0; tick(s);
    s.nirq[0] = 1'b0; tick(s);
    s.rst = 1'b1; tick(s); repeat (2) tick(s);
    s.rst = 1'b0; repeat (6) tick(s);
    s.nirq[0] = 1'b1; repeat (4) tick(s);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) s.nirq[b] = ~s.nirq[b];
      s.nnmi = ($urandom_range(0, 19) != 0);
      s.nso  = ($urandom_range(0, 15) != 0);
      s.t0   = ($urandom_range(0, 3) == 0);
      s.nt   = ($urandom_range(0, 3) != 0);
      s.ack  = ($urandom_range(0, 5) == 0) && !(s.t0 && s.nt) && !s.ack;
      if ($urandom_range(0, 15) == 0) s.en    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0)  s.imask = 1'($urandom_range(0, 1));
      tick(s);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_priority_ctrl.md
Name: irq_priority_ctrl

Overview:
Parametrised successor to the 6502 core's interrupt front end. Synchronises N_IRQ maskable request lines plus NMI and SO, and supports per-channel edge or level mode and per-channel enables. Resolves fixed priority and latches the interrupt decision at the instruction boundary (T0), with an acknowledge handshake from the core's interrupt sequence. It sits between the system interrupt wires (VIAs, FDC, ACIA, etc.) and the CPU sequencer.

Parameters:
N_IRQ, 4, number of maskable IRQ channels (1..16); channel 0 has highest priority.
SYNC_STAGES, 2, synchroniser flops on every asynchronous input (≥2).
EDGE_MODE, {N_IRQ{1'b0}}, per-channel mode: 1 = falling-edge sticky, 0 = active-low level.
IDX_W, $clog2(N_IRQ) (min 1), width of irq_idx; derived, not overridden.

Ports:
clk  in  1  system clock.
RESET  in  1  asynchronous, active-high reset.
nIRQ  in  N_IRQ  active-low interrupt lines, asynchronous.
nNMI  in  1  active-low NMI, falling-edge sensitive, asynchronous.
nSO  in  1  active-low set-overflow, falling-edge sensitive, asynchronous.
T0  in  1  CPU is in the final cycle of the current instruction.
NEXT_T  in  1  CPU cycle-advance enable; decisions update only when high.
I_mask  in  1  CPU I flag; 1 masks all IRQ channels.
irq_en  in  N_IRQ  per-channel enable.
ack  in  1  one-clk pulse: CPU has fetched the vector for the latched interrupt.
nNMI_req  out  1  low = NMI pending.
nIRQ_req  out  1  low = unmasked, enabled IRQ pending.
nNMI_T0  out  1  low = NMI sequence chosen at last T0.
nIRQ_T0  out  1  low = IRQ sequence chosen at last T0.
irq_idx  out  IDX_W  channel chosen at last T0.
irq_pending  out  N_IRQ  raw pending vector, before enable and mask.
SO_req  out  1  one-clk pulse that sets the V flag.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - Synchroniser flops → 1; pending, NMI latch and SO latch → 0.
  - Outputs: nNMI_req=1, nIRQ_req=1, nNMI_T0=1, nIRQ_T0=1, irq_idx=0, irq_pending=0, SO_req=0.
  - A line held low through reset produces no edge after reset deassertion.
- Synchronisation: input change before rising edge 1 → last sync stage updated at edge SYNC_STAGES → pending/latch register updated at edge SYNC_STAGES+1 (edge 3 at default).
- Edge detection: compare the last sync stage with its previous value, every clk, independent of NEXT_T.
- Level channel i: pending[i] = registered copy of ~sync(nIRQ[i]); ack has no effect on it.
- Edge channel i: pending[i] sets on a falling edge; it clears only on ack when nIRQ_T0=0 and irq_idx=i. If a new edge and a clearing ack occur in the same clk, set wins.
- NMI: a falling edge sets nmi_latch. Further edges while latched merge into it. ack with nNMI_T0=0 clears the latch; an edge in that same clk keeps it set.
- nNMI_req = ~nmi_latch (combinational from register).
- nIRQ_req = ~(|(pending & irq_en) & ~I_mask) (combinational).
- Decision register, updated on the clk where T0 & NEXT_T:
  - nNMI_T0 <= nNMI_req.
  - nIRQ_T0 <= nIRQ_req | ~nNMI_req (NMI wins over IRQ).
  - irq_idx <= lowest set index of (pending & irq_en); holds its previous value if none is set.
- The decision outputs hold when T0 & NEXT_T is low.
- ack:
  - When nNMI_T0=0: performs the NMI clear and sets nNMI_T0 to 1 next clk.
  - Else when nIRQ_T0=0: performs the edge-channel clear and sets nIRQ_T0 to 1.
  - Else: ignored.
- An IRQ whose level deasserts, or that becomes disabled, after the T0 decision is still serviced (nIRQ_T0 stays low until ack or the next T0 & NEXT_T).
- SO: a falling edge sets so_pend. On the first clk with NEXT_T=1 (the edge clk itself counts), SO_req=1 for exactly one clk and so_pend clears. A second edge before that clk merges into the pending pulse.
- I_mask affects only nIRQ_req and nIRQ_T0; it never affects irq_pending or NMI.

Test Plan:
- Reset, then nIRQ[2]=0 (level), irq_en=4'b1111, I_mask=0 → nIRQ_req low at edge 3; on T0&NEXT_T, nIRQ_T0=0 and irq_idx=2; release line → irq_pending[2]=0 at edge 3 and nIRQ_T0 stays 0 until ack.
- Simultaneous pending on channels 3 and 1 → irq_idx=1. Set irq_en[1]=0, next T0&NEXT_T → irq_idx=3. Set I_mask=1 → nIRQ_req=1 while irq_pending=4'b1010.
- EDGE_MODE=4'b0001: 1-clk low pulse on nIRQ[0] → pending[0] sticky; ack after decision clears it; a second pulse landing in the ack clk leaves pending[0]=1.
- nNMI 1-clk low pulse with IRQ also pending → nNMI_req low at edge 3; at T0&NEXT_T, nNMI_T0=0 and nIRQ_T0=1; ack → nNMI_T0=1, nNMI_req=1, IRQ taken at the next T0.
- NEXT_T=0 and T0=1 with NMI latched → nNMI_T0 stays 1. Hold NEXT_T low through an nSO edge → SO_req=0 until NEXT_T rises, then exactly one-clk pulse.
- Assert RESET mid-sequence with nNMI_T0=0 and edge pending → all outputs at reset values immediately. Keep nIRQ[0] (edge) low through reset release → no pending after release.
